// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order front end: functional-unit and ALU encodings,
// the decoded-instruction bundle, RV32I opcodes and the decode skid-buffer states.
package ooo_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FUNCT3_W = 3;

  typedef enum logic [3:0] {
    FU_ALU     = 4'd0,
    FU_BRANCH  = 4'd1,
    FU_JUMP    = 4'd2,
    FU_LOAD    = 4'd3,
    FU_STORE   = 4'd4,
    FU_SYS     = 4'd5,
    FU_ILLEGAL = 4'd6
  } fu_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  // a_is_pc selects the PC as ALU operand A (AUIPC).
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
    logic [FUNCT3_W-1:0] funct3;
    logic [XLEN-1:0]     imm;
    fu_t                 fu;
    alu_op_t             alu_op;
    logic                a_is_pc;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Maps funct3 to an ALU op; alt is instr[30], allow_sub is 0 for OP-IMM.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    alu_op_t op;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I decoder: instruction word and PC to decoded_t.
module rv32i_decoder
  import ooo_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u = {instr[31:12], 12'b0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects compressed encodings.
  always_comb begin
    dec           = '0;
    dec.pc        = pc;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.funct3    = instr[14:12];
    dec.fu        = FU_ILLEGAL;
    dec.alu_op    = ALU_ADD;
    dec.illegal   = 1'b1;
    case (instr[6:0])
      OPC_LUI: begin
        dec.fu        = FU_ALU;
        dec.alu_op    = ALU_PASSB;
        dec.imm       = w_imm_u;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_AUIPC: begin
        dec.fu        = FU_ALU;
        dec.imm       = w_imm_u;
        dec.a_is_pc   = 1'b1;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_JAL: begin
        dec.fu        = FU_JUMP;
        dec.imm       = w_imm_j;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_JALR: begin
        dec.fu        = FU_JUMP;
        dec.imm       = w_imm_i;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_BRANCH: begin
        dec.fu       = FU_BRANCH;
        dec.imm      = w_imm_b;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.illegal  = 1'b0;
      end
      OPC_LOAD: begin
        dec.fu        = FU_LOAD;
        dec.imm       = w_imm_i;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_STORE: begin
        dec.fu       = FU_STORE;
        dec.imm      = w_imm_s;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.illegal  = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.fu        = FU_ALU;
        dec.alu_op    = alu_from_f3(instr[14:12], instr[30], 1'b0);
        dec.imm       = w_imm_i;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_OP: begin
        dec.fu        = FU_ALU;
        dec.alu_op    = alu_from_f3(instr[14:12], instr[30], 1'b1);
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.fu      = FU_SYS;
        dec.imm     = w_imm_i;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
    if (dec.rd == REG_AW'(0)) dec.writes_rd = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: RV32I decoder feeding a two-entry skid buffer (main M, skid S)
// so that ready_out toward fetch is a pure register output.
module decode_stage
  import ooo_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  T         instr_in,
  input  T         pc_in,
  input  logic     valid_in,
  output logic     ready_out,
  output decoded_t dec_out,
  output logic     valid_out,
  input  logic     ready_in
);

  skid_state_t r_state;
  skid_state_t w_next;
  logic        r_valid;
  logic        r_ready;
  decoded_t    r_m;
  decoded_t    r_s;
  decoded_t    w_dec;
  logic        w_accept;
  logic        w_emit;
  logic        w_load_m;
  logic        w_m_from_s;
  logic        w_load_s;

  rv32i_decoder u_dec (
    .instr (XLEN'(instr_in)),
    .pc    (XLEN'(pc_in)),
    .dec   (w_dec)
  );

  assign w_accept = valid_in && r_ready && !flush;
  assign w_emit   = r_valid && ready_in;

  // Next state and register-load controls; flush overrides everything.
  always_comb begin
    w_next     = r_state;
    w_load_m   = 1'b0;
    w_m_from_s = 1'b0;
    w_load_s   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next   = ST_ONE;
          w_load_m = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_load_m = 1'b1;
        end else if (w_accept) begin
          w_next   = ST_FULL;
          w_load_s = 1'b1;
        end else if (w_emit) begin
          w_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_next     = ST_ONE;
          w_load_m   = 1'b1;
          w_m_from_s = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
    if (flush) begin
      w_next     = ST_EMPTY;
      w_load_m   = 1'b0;
      w_m_from_s = 1'b0;
      w_load_s   = 1'b0;
    end
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != ST_EMPTY);
      r_ready <= (w_next != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_load_m) r_m <= w_m_from_s ? r_s : w_dec;
      if (w_load_s) r_s <= w_dec;
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_valid;
  assign dec_out   = r_m;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-decoded bundles, a monitor
// pops and compares each bundle the stage hands downstream.
module tb_decode_stage;
  import ooo_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        valid_in;
  logic        ready_out;
  decoded_t    dec_out;
  logic        valid_out;
  logic        ready_in;

  int total = 0;
  int bad   = 0;
  decoded_t exp_q[$];

  decode_stage #(.T(logic [31:0])) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .dec_out   (dec_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decoded_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                  input logic [2:0] f3, input logic [31:0] imm,
                                  input fu_t fu, input alu_op_t op, input logic apc,
                                  input logic u1, u2, wr, ill);
    decoded_t d;
    d.pc = pc; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.funct3 = f3; d.imm = imm;
    d.fu = fu; d.alu_op = op; d.a_is_pc = apc;
    d.uses_rs1 = u1; d.uses_rs2 = u2; d.writes_rd = wr; d.illegal = ill;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Present one instruction, hold until accepted, then push its expected decode.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input decoded_t e);
    int n;
    n = 0;
    @(negedge clk);
    instr_in = ins; pc_in = pc; valid_in = 1'b1;
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) chk("send_timeout", 128'(ready_out), 128'(1));
    else exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    ready_in = 1'b1;
    repeat (n) @(negedge clk);
    #3;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every downstream handshake must match the head of the scoreboard.
  initial begin
    decoded_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 128'(dec_out), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("dec_out", 128'(dec_out), 128'(e));
        end
      end
    end
  end

  decoded_t v_addi, v_beq, v_lui, v_sw, v_zero, v_nop;
  decoded_t s_add, s_sub, s_srai, s_jal, p_auipc, r_lui;

  initial begin
    v_addi  = mk(32'h0, 5'd0, 5'd5, 5'd1, 3'd0, 32'd5, FU_ALU, ALU_ADD, 0, 1, 0, 1, 0);
    v_beq   = mk(32'h4, 5'd1, 5'd2, 5'd25, 3'd0, 32'hFFFFFFF8, FU_BRANCH, ALU_ADD, 0, 1, 1, 0, 0);
    v_lui   = mk(32'h8, 5'd8, 5'd3, 5'd5, 3'd5, 32'h12345000, FU_ALU, ALU_PASSB, 0, 0, 0, 1, 0);
    v_sw    = mk(32'hC, 5'd1, 5'd2, 5'd12, 3'd2, 32'd12, FU_STORE, ALU_ADD, 0, 1, 1, 0, 0);
    v_zero  = mk(32'h10, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, FU_ILLEGAL, ALU_ADD, 0, 0, 0, 0, 1);
    v_nop   = mk(32'h14, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, FU_ALU, ALU_ADD, 0, 1, 0, 0, 0);
    s_add   = mk(32'h100, 5'd1, 5'd2, 5'd2, 3'd0, 32'd0, FU_ALU, ALU_ADD, 0, 1, 1, 1, 0);
    s_sub   = mk(32'h104, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, FU_ALU, ALU_SUB, 0, 1, 1, 1, 0);
    s_srai  = mk(32'h108, 5'd1, 5'd3, 5'd4, 3'd5, 32'h403, FU_ALU, ALU_SRA, 0, 1, 0, 1, 0);
    s_jal   = mk(32'h10C, 5'd0, 5'd16, 5'd1, 3'd0, 32'd16, FU_JUMP, ALU_ADD, 0, 0, 0, 1, 0);
    p_auipc = mk(32'h200, 5'd0, 5'd0, 5'd7, 3'd1, 32'h1000, FU_ALU, ALU_ADD, 1, 0, 0, 1, 0);
    r_lui   = mk(32'h400, 5'd8, 5'd3, 5'd5, 3'd5, 32'h12345000, FU_ALU, ALU_PASSB, 0, 0, 0, 1, 0);

    reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    instr_in = '0; pc_in = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_ready_out", 128'(ready_out), 128'(1));
    chk("rst_dec_out", 128'(dec_out), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed decodes streamed back to back with downstream always ready.
    ready_in = 1'b1;
    send(32'h00500093, 32'h0, v_addi);
    send(32'hFE208CE3, 32'h4, v_beq);
    send(32'h123452B7, 32'h8, v_lui);
    send(32'h0020A623, 32'hC, v_sw);
    send(32'h00000000, 32'h10, v_zero);
    send(32'h00000013, 32'h14, v_nop);
    idle();
    drain(5);

    // Skid: downstream stalls, S fills after two accepts, then release.
    @(negedge clk);
    ready_in = 1'b0;
    send(32'h00208133, 32'h100, s_add);
    send(32'h402081B3, 32'h104, s_sub);
    fork
      begin
        send(32'h4030D213, 32'h108, s_srai);
        send(32'h010000EF, 32'h10C, s_jal);
        idle();
      end
      begin
        @(negedge clk);
        #1;
        chk("skid_ready_low", 128'(ready_out), 128'(0));
        chk("skid_valid_hi", 128'(valid_out), 128'(1));
        chk("skid_hold_m", 128'(dec_out), 128'(s_add));
        repeat (2) @(negedge clk);
        ready_in = 1'b1;
        @(negedge clk);
        #1;
        chk("skid_ready_back", 128'(ready_out), 128'(1));
      end
    join
    drain(6);

    // Flush with M and S occupied and a new instruction on the input.
    @(negedge clk);
    ready_in = 1'b0;
    send(32'h00208133, 32'h300, s_add);
    send(32'h402081B3, 32'h304, s_sub);
    @(negedge clk);
    instr_in = 32'h4030D213; pc_in = 32'h308; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid_out", 128'(valid_out), 128'(0));
    chk("flush_ready_out", 128'(ready_out), 128'(1));
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    send(32'h00001397, 32'h200, p_auipc);
    idle();
    drain(5);

    // Asynchronous reset between edges while the stage is stalled full.
    @(negedge clk);
    ready_in = 1'b0;
    send(32'h00208133, 32'h100, s_add);
    send(32'h402081B3, 32'h104, s_sub);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("areset_valid_out", 128'(valid_out), 128'(0));
    chk("areset_ready_out", 128'(ready_out), 128'(1));
    chk("areset_dec_out", 128'(dec_out), 128'(0));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    ready_in = 1'b1;
    send(32'h123452B7, 32'h400, r_lui);
    idle();
    drain(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Single-issue RV32I decode stage. It sits directly downstream of the fetch stage and upstream of rename/dispatch. It accepts one `{instr, pc}` pair per valid/ready handshake and emits one registered decoded-instruction bundle. A two-entry skid buffer gives a fully registered `ready_out` toward fetch, so there is no combinational ready path through the stage. A branch redirect flushes all in-flight entries.

## Interface
- `T`, default `logic [31:0]`, type of instruction word and PC.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  branch redirect; same net as fetch `take_branch`.
- `instr_in`  in  32  instruction from fetch.
- `pc_in`  in  32  PC of `instr_in`.
- `valid_in`  in  1  fetch holds a valid instruction.
- `ready_out`  out  1  stage can accept; registered.
- `dec_out`  out  `decoded_t`  decoded bundle (fields below).
- `valid_out`  out  1  `dec_out` is valid.
- `ready_in`  in  1  downstream accepts `dec_out` this cycle.

## Operation
- Transfers:
  - Accept when `valid_in && ready_out && !flush`.
  - Emit when `valid_out && ready_in`.
- Storage: main register M (drives outputs) and skid register S. Each has its own valid bit.
- State/transitions (`{M.v, S.v}`):
  - EMPTY `{0,0}`: on accept, → ONE (M loaded).
  - ONE `{1,0}`:
    - accept and emit: M reloaded, stays ONE.
    - accept, no emit: S loaded, → FULL.
    - emit, no accept: → EMPTY.
  - FULL `{1,1}`: `ready_out=0`. On emit, S moves to M, → ONE.
- `ready_out` is registered and equals `!S.v` of the next state. `{0,1}` is unreachable.
- Decoding is combinational on `instr_in` and is written into M or S at accept. Fields of `decoded_t`:
  - `pc`, `rs1`, `rs2`, `rd`, `funct3`.
  - `imm` (32b, sign-extended per I/S/B/U/J format; U = `instr[31:12]<<12`).
  - `fu` (`fu_t`: ALU, BRANCH, JUMP, LOAD, STORE, SYS, ILLEGAL).
  - `alu_op` (`alu_op_t`: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB).
  - `uses_rs1`, `uses_rs2`, `writes_rd`, `illegal`.
- Opcode rules:
  - LUI: ALU, PASSB, imm=U, no rs.
  - AUIPC: ALU, ADD, imm=U, operand A = pc, no rs.
  - JAL: JUMP, J-imm.
  - JALR: JUMP, I-imm, uses_rs1.
  - BRANCH: B-imm, uses rs1 and rs2, `writes_rd=0`.
  - LOAD: I-imm. STORE: S-imm, uses rs1 and rs2, `writes_rd=0`.
  - OP-IMM: SUB never chosen; SRAI when `instr[30]`.
  - OP: SUB/SRA when `instr[30]`.
  - MISC-MEM and SYSTEM: fu=SYS, no register use.
- `writes_rd` is forced to 0 when `rd==0`.
- Any other opcode, or `instr[1:0]!=2'b11`, gives `illegal=1`, fu=ILLEGAL, all use/write flags 0. The entry still propagates so commit can trap.

## Timing
- Latency: accept at edge N, so `valid_out` is high after edge N, valid for the cycle N→N+1.
- Throughput: 1/cycle while `ready_in=1`.
- Stalls:
  - `ready_in` low for one cycle with a new input costs one skid entry.
  - `ready_out` drops on the edge after S fills and rises on the edge after S drains.
- `flush` (synchronous):
  - At the next edge, M.v=S.v=0 and `ready_out=1`.
  - Input presented in the flush cycle is discarded.
  - Flush beats any simultaneous accept or emit; an emit in that cycle still counts as taken by downstream.
- Downstream must not depend on `dec_out` while `valid_out=0`. `dec_out` is held stable while `valid_out && !ready_in`.
- Reset (asynchronous; applies any time, including mid-stall):
  - `valid_out=0`, `ready_out=1`, both valid bits 0, all `dec_out` fields 0.
  - Normal operation resumes on the first edge after deassertion.

## Structure
- Shared package `ooo_pkg` holds:
  - `fu_t` and `alu_op_t` (enum, 4b each);
  - `decoded_t` (packed struct);
  - RV32I opcode localparams (`OPC_LUI`…`OPC_SYSTEM`).
- One combinational sub-module `rv32i_decoder` (`instr`, `pc` → `decoded_t`).
- `decode_stage` holds only the skid control and the M/S registers.

## Test plan
- Pass-through: `0x00500093` @pc `0x0`, `ready_in=1` → next cycle `valid_out=1`, rd=1, rs1=0, imm=5, fu=ALU, alu_op=ADD, writes_rd=1.
- Immediates:
  - `0xFE208CE3` (beq x1,x2,-8) → imm=`0xFFFFFFF8`, fu=BRANCH, uses_rs1/rs2=1, writes_rd=0.
  - `0x123452B7` (lui x5) → imm=`0x12345000`, rd=5.
  - `0x0020A623` (sw x2,12(x1)) → imm=12, fu=STORE.
- Skid: stream 4 instrs, hold `ready_in=0` 3 cycles → `ready_out` low after 2 accepts. Release → all 4 emerge in order, none lost or duplicated.
- Flush in FULL: assert `flush` with M and S occupied and `valid_in=1` → next cycle `valid_out=0`, `ready_out=1`; the flushed instrs never appear.
- Illegal and x0:
  - `0x00000000` → illegal=1, fu=ILLEGAL.
  - `0x00000013` (addi x0) → writes_rd=0.
- Async reset: assert `reset` mid-stall between edges → `valid_out=0` and `ready_out=1` immediately, before the next edge.
